// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared defaults, derived widths and fetch tag type for the framebuffer fetch path
package vga_pkg;

  localparam int H_RES_DEF   = 640;
  localparam int V_RES_DEF   = 480;
  localparam int PIX_W_DEF   = 12;
  localparam int SLOT_W_DEF  = 16;
  localparam int WORD_W_DEF  = 32;
  localparam int RAM_LAT_DEF = 1;
  localparam int ADDR_W_DEF  = 19;

  localparam int ROW_W = $clog2(V_RES_DEF);
  localparam int COL_W = $clog2(H_RES_DEF);

  // Wide enough for up to 256 slots per word.
  localparam int TAG_SLOT_W = 8;

  typedef struct packed {
    logic                  valid;
    logic                  in_range;
    logic                  reuse;
    logic [TAG_SLOT_W-1:0] slot;
  } fetch_tag_t;

  function automatic int frame_words(input int h_res, input int v_res, input int slots);
    return (h_res * v_res) / slots;
  endfunction

endpackage

// File: rtl/vga_tag_delay.sv
// rtl/vga_tag_delay.sv - fixed-depth shift register carrying fetch tags alongside outstanding RAM reads
module vga_tag_delay
  import vga_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  fetch_tag_t tag_in,
  output fetch_tag_t tag_out
);

  fetch_tag_t pipe_q [DEPTH];
  fetch_tag_t pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_fb_fetch.sv
// rtl/vga_fb_fetch.sv - framebuffer fetch: (row,col) to packed RAM word read to unpacked pixel, fixed latency
// Double-buffered frame base switching is enabled by defining VGA_FB_DOUBLE_BUF_EN.
module vga_fb_fetch
  import vga_pkg::*;
#(
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF,
  parameter int PIX_W   = PIX_W_DEF,
  parameter int SLOT_W  = SLOT_W_DEF,
  parameter int WORD_W  = WORD_W_DEF,
  parameter int RAM_LAT = RAM_LAT_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_req,
  input  logic [ROW_W-1:0]  row_addr,
  input  logic [COL_W-1:0]  col_addr,
  input  logic              frame_end,
  input  logic              swap_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [WORD_W-1:0] ram_rdata,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  output logic              front_buf,
  output logic              swap_done
);

  localparam int SLOTS     = WORD_W / SLOT_W;
  localparam int SHIFT     = $clog2(SLOTS);
  localparam int PIX_CNT   = H_RES * V_RES;
  localparam int IDX_W     = $clog2(PIX_CNT);
  localparam int BUF_WORDS = frame_words(H_RES, V_RES, SLOTS);

  logic front_sel;
  logic swap_fire;

`ifdef VGA_FB_DOUBLE_BUF_EN
  localparam bit DBL_EN = 1'b1;

  logic pending_q, pending_d;
  logic front_buf_q, front_buf_d;
  logic swap_done_q, swap_done_d;

  // A swap_req arriving together with frame_end is honoured at that same frame_end.
  always_comb begin
    swap_fire   = frame_end && (pending_q || swap_req);
    pending_d   = swap_fire ? 1'b0 : (pending_q || swap_req);
    front_buf_d = front_buf_q ^ swap_fire;
    swap_done_d = swap_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= 1'b0;
      front_buf_q <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      front_buf_q <= front_buf_d;
      swap_done_q <= swap_done_d;
    end
  end

  assign front_sel = front_buf_q;
  assign front_buf = front_buf_q;
  assign swap_done = swap_done_q;
`else
  localparam bit DBL_EN = 1'b0;

  logic unused_swap;
  assign unused_swap = swap_req ^ frame_end;
  assign swap_fire   = 1'b0;
  assign front_sel   = 1'b0;
  assign front_buf   = 1'b0;
  assign swap_done   = 1'b0;
`endif

  logic [IDX_W-1:0] pix_idx_q, pix_idx_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_in_range_q, s1_in_range_d;

  always_comb begin
    pix_idx_d     = IDX_W'(32'(row_addr) * 32'(H_RES) + 32'(col_addr));
    s1_in_range_d = (32'(row_addr) < 32'(V_RES)) && (32'(col_addr) < 32'(H_RES));
    s1_valid_d    = pix_req;
  end

  logic [ADDR_W-1:0] base, word;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [ADDR_W-1:0] last_word_q, last_word_d;
  logic              hist_q, hist_d;
  logic              ram_rd_q, ram_rd_d;
  logic              issue_ok;
  fetch_tag_t        s2_tag_q, s2_tag_d;

  // hist_q marks that the previous S2 cycle touched last_word_q, so a matching word can skip the RAM.
  always_comb begin
    base              = front_sel ? ADDR_W'(BUF_WORDS) : '0;
    word              = base + ADDR_W'(pix_idx_q >> SHIFT);
    issue_ok          = s1_valid_q && s1_in_range_q;
    s2_tag_d.valid    = s1_valid_q;
    s2_tag_d.in_range = s1_in_range_q;
    s2_tag_d.reuse    = issue_ok && hist_q && (word == last_word_q);
    s2_tag_d.slot     = TAG_SLOT_W'(pix_idx_q & IDX_W'(SLOTS - 1));
    ram_rd_d          = issue_ok && !s2_tag_d.reuse;
    ram_addr_d        = ram_rd_d ? word : ram_addr_q;
    last_word_d       = ram_rd_d ? word : last_word_q;
    hist_d            = issue_ok && !swap_fire;
  end

  fetch_tag_t rd_tag;

  vga_tag_delay #(
    .DEPTH (RAM_LAT)
  ) u_tag_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (s2_tag_q),
    .tag_out (rd_tag)
  );

  logic [WORD_W-1:0] held_word_q, held_word_d;
  logic [WORD_W-1:0] sel_word;
  logic [SLOT_W-1:0] slot_bits;
  logic [PIX_W-1:0]  pix_data_q, pix_data_d;
  logic              pix_valid_q, pix_valid_d;

  always_comb begin
    sel_word  = rd_tag.reuse ? held_word_q : ram_rdata;
    slot_bits = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if (rd_tag.slot == TAG_SLOT_W'(k)) begin
        slot_bits = sel_word[k*SLOT_W +: SLOT_W];
      end
    end
    pix_valid_d = rd_tag.valid;
    pix_data_d  = (rd_tag.valid && rd_tag.in_range) ? slot_bits[PIX_W-1:0] : '0;
    held_word_d = (rd_tag.valid && rd_tag.in_range && !rd_tag.reuse) ? ram_rdata : held_word_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_idx_q     <= '0;
      s1_valid_q    <= 1'b0;
      s1_in_range_q <= 1'b0;
      ram_addr_q    <= '0;
      ram_rd_q      <= 1'b0;
      last_word_q   <= '0;
      hist_q        <= 1'b0;
      s2_tag_q      <= '0;
      held_word_q   <= '0;
      pix_data_q    <= '0;
      pix_valid_q   <= 1'b0;
    end else begin
      pix_idx_q     <= pix_idx_d;
      s1_valid_q    <= s1_valid_d;
      s1_in_range_q <= s1_in_range_d;
      ram_addr_q    <= ram_addr_d;
      ram_rd_q      <= ram_rd_d;
      last_word_q   <= last_word_d;
      hist_q        <= hist_d;
      s2_tag_q      <= s2_tag_d;
      held_word_q   <= held_word_d;
      pix_data_q    <= pix_data_d;
      pix_valid_q   <= pix_valid_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_rd    = ram_rd_q;
  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;

  localparam longint MAX_WORD = longint'(DBL_EN ? BUF_WORDS : 0) + longint'((PIX_CNT - 1) / SLOTS);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (MAX_WORD < (longint'(1) << ADDR_W)) else $error("vga_fb_fetch: frame words overflow ADDR_W");
      assert (PIX_W <= SLOT_W && RAM_LAT >= 1) else $error("vga_fb_fetch: bad PIX_W/SLOT_W/RAM_LAT");
      assert (SLOTS >= 1 && (SLOTS & (SLOTS - 1)) == 0) else $error("vga_fb_fetch: SLOTS not a power of two");
    end
  end

endmodule

// File: tb/tb_vga_fb_fetch.sv
// tb/tb_vga_fb_fetch.sv - randomized scoreboard bench for vga_fb_fetch against a pixel-level reference model
`timescale 1ns/1ps
module tb_vga_fb_fetch;

  localparam int LAT       = 3;
  localparam int H         = 640;
  localparam int V         = 480;
  localparam int BUF_WORDS = H * V / 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_req = 1'b0;
  logic [8:0]  row_addr = '0;
  logic [9:0]  col_addr = '0;
  logic        frame_end = 1'b0;
  logic        swap_req = 1'b0;
  logic [18:0] ram_addr;
  logic        ram_rd;
  logic [31:0] ram_rdata;
  logic [11:0] pix_data;
  logic        pix_valid;
  logic        front_buf;
  logic        swap_done;

  vga_fb_fetch #(
    .H_RES   (H),
    .V_RES   (V),
    .PIX_W   (12),
    .SLOT_W  (16),
    .WORD_W  (32),
    .RAM_LAT (LAT),
    .ADDR_W  (19)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_req   (pix_req),
    .row_addr  (row_addr),
    .col_addr  (col_addr),
    .frame_end (frame_end),
    .swap_req  (swap_req),
    .ram_addr  (ram_addr),
    .ram_rd    (ram_rd),
    .ram_rdata (ram_rdata),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .front_buf (front_buf),
    .swap_done (swap_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [18:0] a);
    if (a == 19'd0) return 32'h0ABC_0123;
    if (a == 19'd1) return 32'h0DEF_0456;
    return ({13'd0, a} * 32'h9E37_79B1) ^ {a[12:0], a};
  endfunction

  // RAM: data for a read strobed in cycle X is presented during cycle X+LAT, junk otherwise.
  logic        st_vld  [LAT];
  logic [18:0] st_addr [LAT];
  logic [31:0] junk;
  always @(posedge clk) begin
    st_vld[0]  <= ram_rd;
    st_addr[0] <= ram_addr;
    for (int i = 1; i < LAT; i++) begin
      st_vld[i]  <= st_vld[i-1];
      st_addr[i] <= st_addr[i-1];
    end
    junk <= $urandom;
  end
  assign ram_rdata = st_vld[LAT-1] ? mem_word(st_addr[LAT-1]) : junk;

  typedef struct { int cyc; logic [11:0] pix; } pix_exp_t;
  typedef struct { int cyc; logic [18:0] addr; } rd_exp_t;
  pix_exp_t pix_q[$];
  rd_exp_t  rd_q[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic        m_prev_in = 1'b0;
  logic [18:0] m_prev_word = '0;
  logic        m_front = 1'b0;

  function automatic logic [18:0] model_word(input int row, input int col);
    return 19'((m_front ? BUF_WORDS : 0) + (row * H + col) / 2);
  endfunction

  task automatic drive(input logic req, input int row, input int col);
    logic        in_r;
    logic [18:0] w;
    logic [31:0] mw;
    pix_exp_t    pe;
    rd_exp_t     re;
    pix_req  = req;
    row_addr = 9'(row);
    col_addr = 10'(col);
    in_r     = req && row < V && col < H;
    w        = model_word(row, col);
    if (req) begin
      mw     = mem_word(w);
      pe.cyc = cyc + LAT + 3;
      pe.pix = !in_r ? 12'h000 : (((row * H + col) % 2) != 0 ? mw[27:16] : mw[11:0]);
      pix_q.push_back(pe);
      if (in_r && !(m_prev_in && m_prev_word == w)) begin
        re.cyc  = cyc + 2;
        re.addr = w;
        rd_q.push_back(re);
      end
    end
    m_prev_in   = in_r;
    m_prev_word = w;
  endtask

  task automatic step(input logic req, input int row, input int col);
    @(negedge clk);
    drive(req, row, col);
  endtask

  task automatic step_exp(input int row, input int col, input logic [11:0] pix,
                          input logic rd, input logic [18:0] addr);
    pix_exp_t pe;
    rd_exp_t  re;
    @(negedge clk);
    pix_req  = 1'b1;
    row_addr = 9'(row);
    col_addr = 10'(col);
    pe.cyc = cyc + LAT + 3;
    pe.pix = pix;
    pix_q.push_back(pe);
    if (rd) begin
      re.cyc  = cyc + 2;
      re.addr = addr;
      rd_q.push_back(re);
    end
    m_prev_in   = row < V && col < H;
    m_prev_word = model_word(row, col);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_pix_data"},  32'(pix_data),  32'd0);
    check({tag, "_ram_rd"},    32'(ram_rd),    32'd0);
  endtask

  pix_exp_t mp;
  rd_exp_t  mr;
  always @(negedge clk) begin
    if (rst_n) begin
      while (pix_q.size() != 0 && pix_q[0].cyc < cyc) begin
        mp = pix_q.pop_front();
        checks++; errors++;
        $display("FAIL pix_missing: no pixel at cycle %0d, expected 0x%0h", mp.cyc, mp.pix);
      end
      while (rd_q.size() != 0 && rd_q[0].cyc < cyc) begin
        mr = rd_q.pop_front();
        checks++; errors++;
        $display("FAIL rd_missing: no ram_rd at cycle %0d, expected addr %0d", mr.cyc, mr.addr);
      end
      if (pix_valid) begin
        if (pix_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pix_unexpected: pix_valid=1 data=0x%0h, required no pixel", pix_data);
        end else begin
          mp = pix_q.pop_front();
          check("pix_data", 32'(pix_data), 32'(mp.pix));
          check("pix_latency", 32'(cyc), 32'(mp.cyc));
        end
      end
      if (ram_rd) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: ram_rd=1 addr=%0d, required no read", ram_addr);
        end else begin
          mr = rd_q.pop_front();
          check("ram_addr", 32'(ram_addr), 32'(mr.addr));
          check("rd_latency", 32'(cyc), 32'(mr.cyc));
        end
      end
    end
  end

  initial begin
    int          r, c;
    logic [31:0] w;

    pix_req  = 1'b1;
    row_addr = 9'd0;
    col_addr = 10'd7;
    repeat (3) begin
      @(negedge clk);
      check_quiet("reset");
      check("reset_ram_addr",  32'(ram_addr),  32'd0);
      check("reset_front_buf", 32'(front_buf), 32'd0);
      check("reset_swap_done", 32'(swap_done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 0, 7);
    repeat (2) step(1'b0, 0, 0);

    step_exp(0, 0, 12'h123, 1'b1, 19'd0);
    step_exp(0, 1, 12'hABC, 1'b0, 19'd0);
    step_exp(0, 2, 12'h456, 1'b1, 19'd1);
    step_exp(0, 3, 12'hDEF, 1'b0, 19'd1);
    step(1'b0, 0, 0);
    w = mem_word(19'd322);
    step_exp(1, 5, w[27:16], 1'b1, 19'd322);
    step_exp(0, 640, 12'h000, 1'b0, 19'd0);
    step_exp(480, 0, 12'h000, 1'b0, 19'd0);
    step_exp(0, 0, 12'h123, 1'b1, 19'd0);
    step_exp(0, 640, 12'h000, 1'b0, 19'd0);
    step_exp(0, 1, 12'hABC, 1'b1, 19'd0);
    step(1'b0, 0, 0);
    step_exp(0, 1, 12'hABC, 1'b1, 19'd0);
    w = mem_word(19'd153599);
    step_exp(479, 639, w[27:16], 1'b1, 19'd153599);
    step(1'b0, 0, 0);

`ifdef VGA_FB_DOUBLE_BUF_EN
    @(negedge clk); drive(1'b0, 0, 0); swap_req = 1'b1;
    @(negedge clk); drive(1'b0, 0, 0); swap_req = 1'b1;
    @(negedge clk); drive(1'b0, 0, 0); swap_req = 1'b0; frame_end = 1'b1;
    @(negedge clk); drive(1'b0, 0, 0); frame_end = 1'b0;
    check("swap_done_pulse", 32'(swap_done), 32'd1);
    check("front_after_swap", 32'(front_buf), 32'd1);
    m_front = 1'b1;
    @(negedge clk); drive(1'b0, 0, 0);
    check("swap_done_single", 32'(swap_done), 32'd0);
    check("front_held", 32'(front_buf), 32'd1);
    w = mem_word(19'd153600);
    step_exp(0, 0, w[11:0], 1'b1, 19'd153600);
    step(1'b0, 0, 0);
    @(negedge clk); drive(1'b0, 0, 0); swap_req = 1'b1; frame_end = 1'b1;
    @(negedge clk); drive(1'b0, 0, 0); swap_req = 1'b0; frame_end = 1'b0;
    check("swap_same_cycle_done", 32'(swap_done), 32'd1);
    check("swap_same_cycle_front", 32'(front_buf), 32'd0);
    m_front = 1'b0;
`else
    @(negedge clk); drive(1'b0, 0, 0); swap_req = 1'b1;
    @(negedge clk); drive(1'b0, 0, 0); swap_req = 1'b0; frame_end = 1'b1;
    @(negedge clk); drive(1'b0, 0, 0); frame_end = 1'b0;
    check("nodbl_swap_done", 32'(swap_done), 32'd0);
    check("nodbl_front_buf", 32'(front_buf), 32'd0);
`endif

    r = 0;
    c = 0;
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) begin
        step(1'b0, r, c);
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          c = c + 1;
        end else begin
          r = $urandom_range(0, 495);
          c = $urandom_range(0, 655);
        end
        if (c > 1023) c = 0;
        step(1'b1, r, c);
      end
    end
    repeat (LAT + 6) step(1'b0, 0, 0);

    for (int i = 0; i < 5; i++) step(1'b1, 2, 10 + i);
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    pix_req = 1'b0;
    #1;
    check_quiet("midreset");
    pix_q.delete();
    rd_q.delete();
    m_prev_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 0, 0);
    repeat (LAT + 6) step(1'b0, 0, 0);
    step(1'b1, 0, 2);
    step(1'b1, 0, 3);

    for (int i = 0; i < 40 && (pix_q.size() != 0 || rd_q.size() != 0); i++) step(1'b0, 0, 0);
    checks++;
    if (pix_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pixels and %0d reads still outstanding, required 0", pix_q.size(), rd_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
